// File: rtl/vga_write_arbiter.sv
// Arbitrates the VGA adapter write port between a screen-clear engine and two renderer clients.
// Round-robin grants, pending-clear priority and a per-grant watchdog.
module vga_write_arbiter #(
  parameter int unsigned CLR_W          = 160,
  parameter int unsigned CLR_H          = 120,
  parameter logic [2:0]  CLR_COLOUR     = 3'b000,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned MAX_GNT        = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear_req,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic [7:0] cx0,
  input  logic [7:0] cx1,
  input  logic [6:0] cy0,
  input  logic [6:0] cy1,
  input  logic [2:0] cc0,
  input  logic [2:0] cc1,
  input  logic       cp0,
  input  logic       cp1,
  output logic [1:0] gnt,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot_out,
  output logic       busy,
  output logic       clear_done,
  output logic       wd_err
);

  localparam int unsigned XW = (CLR_W > 1) ? $clog2(CLR_W) : 1;
  localparam int unsigned YW = (CLR_H > 1) ? $clog2(CLR_H) : 1;
  localparam int unsigned WW = (MAX_GNT > 1) ? $clog2(MAX_GNT) : 1;

  typedef enum logic [1:0] {StIdle, StClear, StGnt0, StGnt1} state_e;

  state_e        state_q;
  logic [1:0]    gnt_q;
  logic          last_q;     // 1: client 1 was served last, so client 0 wins the next tie
  logic          pending_q;
  logic [XW-1:0] clr_x_q;
  logic [YW-1:0] clr_y_q;
  logic [WW-1:0] wd_q;
  logic          clear_done_q;
  logic          wd_err_q;

  logic gsel;
  logic last_pixel;
  assign gsel       = (state_q == StGnt1);
  assign last_pixel = (clr_x_q == XW'(CLR_W - 1)) && (clr_y_q == YW'(CLR_H - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      gnt_q        <= 2'b00;
      last_q       <= 1'b1;
      pending_q    <= CLEAR_ON_RESET;
      clr_x_q      <= '0;
      clr_y_q      <= '0;
      wd_q         <= '0;
      clear_done_q <= 1'b0;
      wd_err_q     <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      wd_err_q     <= 1'b0;
      if (clear_req && (state_q != StClear)) pending_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          // Entering CLEAR consumes the pending flag, overriding a same-cycle clear_req.
          if (pending_q) begin
            state_q   <= StClear;
            pending_q <= 1'b0;
            clr_x_q   <= '0;
            clr_y_q   <= '0;
          end else if (req[0] && (!req[1] || last_q)) begin
            state_q <= StGnt0;
            gnt_q   <= 2'b01;
            last_q  <= 1'b0;
            wd_q    <= '0;
          end else if (req[1]) begin
            state_q <= StGnt1;
            gnt_q   <= 2'b10;
            last_q  <= 1'b1;
            wd_q    <= '0;
          end
        end
        StClear: begin
          if (last_pixel) begin
            state_q      <= StIdle;
            clear_done_q <= 1'b1;
            clr_x_q      <= '0;
            clr_y_q      <= '0;
          end else if (clr_x_q == XW'(CLR_W - 1)) begin
            clr_x_q <= '0;
            clr_y_q <= clr_y_q + 1'b1;
          end else begin
            clr_x_q <= clr_x_q + 1'b1;
          end
        end
        StGnt0, StGnt1: begin
          if (done[gsel]) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
          end else if (wd_q == WW'(MAX_GNT - 1)) begin
            state_q  <= StIdle;
            gnt_q    <= 2'b00;
            wd_err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    x_out      = 8'h00;
    y_out      = 7'h00;
    colour_out = 3'b000;
    plot_out   = 1'b0;
    unique case (state_q)
      StIdle: ;
      StClear: begin
        x_out      = 8'(clr_x_q);
        y_out      = 7'(clr_y_q);
        colour_out = CLR_COLOUR;
        plot_out   = 1'b1;
      end
      StGnt0: begin
        x_out      = cx0;
        y_out      = cy0;
        colour_out = cc0;
        plot_out   = cp0;
      end
      StGnt1: begin
        x_out      = cx1;
        y_out      = cy1;
        colour_out = cc1;
        plot_out   = cp1;
      end
    endcase
  end

  assign gnt        = gnt_q;
  assign busy       = (state_q != StIdle);
  assign clear_done = clear_done_q;
  assign wd_err     = wd_err_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter with a 4x2 clear region and a 16-cycle watchdog.
module tb_vga_write_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear_req = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic [7:0] cx0 = 8'h00, cx1 = 8'h00;
  logic [6:0] cy0 = 7'h00, cy1 = 7'h00;
  logic [2:0] cc0 = 3'b000, cc1 = 3'b000;
  logic       cp0 = 1'b0, cp1 = 1'b0;
  logic [1:0] gnt;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot_out, busy, clear_done, wd_err;

  int checks = 0;
  int failures = 0;

  vga_write_arbiter #(
    .CLR_W(4), .CLR_H(2), .CLR_COLOUR(3'b000), .CLEAR_ON_RESET(1'b1), .MAX_GNT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .req(req), .done(done),
    .cx0(cx0), .cx1(cx1), .cy0(cy0), .cy1(cy1), .cc0(cc0), .cc1(cc1), .cp0(cp0), .cp1(cp1),
    .gnt(gnt), .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot_out(plot_out),
    .busy(busy), .clear_done(clear_done), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_plot", 32'(plot_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_xyc", {x_out, y_out, colour_out}, 0);
    chk("rst_pulses", {clear_done, wd_err}, 0);

    // Clear on reset: 8 pixels, x first
    step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("clr_plot", 32'(plot_out), 1);
      chk("clr_x", 32'(x_out), i % 4);
      chk("clr_y", 32'(y_out), i / 4);
      chk("clr_col_busy", {colour_out, busy, clear_done}, 32'b000_1_0);
      step();
    end
    chk("clr_done_pulse", 32'(clear_done), 1);
    chk("clr_busy_fall", 32'(busy), 0);
    step();
    chk("clr_done_once", 32'(clear_done), 0);

    // GNT1 pass-through, stray done, req drop
    req = 2'b10;
    step();
    chk("g1_gnt", 32'(gnt), 32'b10);
    cx1 = 8'h2A; cy1 = 7'h15; cc1 = 3'b101; cp1 = 1'b1;
    cx0 = 8'h11; cy0 = 7'h22; cc0 = 3'b011; cp0 = 1'b0;
    #1;
    chk("g1_out", {x_out, y_out, colour_out, plot_out}, {8'h2A, 7'h15, 3'b101, 1'b1});
    cp0 = 1'b1; cp1 = 1'b0;
    #1;
    chk("g1_cp0_ignored", 32'(plot_out), 0);
    cp0 = 1'b0; cp1 = 1'b1;
    done = 2'b01;
    step();
    done = 2'b00;
    chk("g1_stray_done", 32'(gnt), 32'b10);
    req = 2'b00;
    step();
    chk("g1_req_drop", 32'(gnt), 32'b10);
    done = 2'b10;
    step();
    done = 2'b00;
    chk("g1_release", {gnt, plot_out, x_out}, 0);

    // Round robin under continuous contention
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'b01 : 32'b10);
      step();
      step();
      chk("rr_hold", 32'(gnt), (k % 2 == 0) ? 32'b01 : 32'b10);
      done = (k % 2 == 0) ? 2'b01 : 2'b10;
      step();
      done = 2'b00;
      chk("rr_idle", {gnt, busy}, 0);
    end

    // Clear requested mid-grant runs before the other client
    step();
    chk("cg_gnt0", 32'(gnt), 32'b01);
    clear_req = 1'b1;
    step();
    step();
    clear_req = 1'b0;
    chk("cg_still_gnt0", 32'(gnt), 32'b01);
    done = 2'b01;
    step();
    done = 2'b00;
    chk("cg_idle", {gnt, busy}, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("cg_clear", {gnt, plot_out, busy}, 32'b00_1_1);
      clear_req = (i == 3);
      step();
    end
    clear_req = 1'b0;
    chk("cg_done", {clear_done, gnt}, 32'b1_00);
    step();
    chk("cg_gnt1_next", {gnt, plot_out}, {2'b10, 1'b1});
    req = 2'b00;
    done = 2'b10;
    step();
    done = 2'b00;

    // Watchdog revokes client 0 after 16 cycles, client 1 follows
    req = 2'b01;
    step();
    chk("wd_gnt0", 32'(gnt), 32'b01);
    req = 2'b11;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("wd_hold", {gnt, wd_err}, 32'b01_0);
    end
    step();
    chk("wd_revoke", {gnt, wd_err}, 32'b00_1);
    step();
    chk("wd_next_gnt1", {gnt, wd_err}, 32'b10_0);
    req = 2'b00;
    done = 2'b10;
    step();
    done = 2'b00;

    // Reset in the middle of a clear
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step();
    chk("mr_pix0", {x_out, y_out, plot_out}, {8'd0, 7'd0, 1'b1});
    repeat (5) step();
    chk("mr_pix5", {x_out, y_out, plot_out}, {8'd1, 7'd1, 1'b1});
    reset_n = 1'b0;
    #1;
    chk("mr_outs_zero", {x_out, y_out, colour_out, plot_out, busy, gnt}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_done", {clear_done, wd_err}, 0);
    end
    reset_n = 1'b1;
    step();
    chk("mr_restart", {x_out, y_out, plot_out}, {8'd0, 7'd0, 1'b1});
    repeat (8) step();
    chk("mr_full_clear_done", {clear_done, busy}, 32'b1_0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
